// File: rtl/seq_ctrl_pkg.sv
// Shared types for the sequence-detector controller: FSM state encoding and
// the counter-width helper used to size hit and position fields.
`timescale 1ns/1ps
package seq_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DONE} state_t;

  // Width needed to hold any value 0..width (hit count and 1-based bit index).
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: takes a parallel word over valid/ready, clears the external
// Moore sequence detector, streams the word MSB-first into it one bit per
// clock and counts the detector hits. The result is reported with a one-cycle
// done pulse and held until the next word is accepted.
// Optional build macro: SEQ_CTRL_HIT_POS_EN adds first_hit_pos, the 1-based
// index of the bit that completed the first hit of the word (0 if none).
`timescale 1ns/1ps
module seq_det_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_rst,
  output logic             det_ser,
  input  logic             det_w,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt
`ifdef SEQ_CTRL_HIT_POS_EN
  ,
  output logic [CNT_W-1:0] first_hit_pos
`endif
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_idx;
  logic             sample;
  logic             hit;

  // The shift register only ever holds zeros outside SHIFT (cleared by the
  // final shifts and by reset), so its MSB doubles as the registered serial
  // output: the current bit in SHIFT, 0 in TAIL/DONE/IDLE.
  assign det_ser = shreg[WIDTH-1];

  // det_w lags the serial bit by one cycle: the first SHIFT cycle still shows
  // the cleared detector, and TAIL shows the verdict on the last bit.
  always_comb begin
    sample = 1'b0;
    case (state)
      SHIFT:   sample = (bit_idx != '0);
      TAIL:    sample = 1'b1;
      default: sample = 1'b0;
    endcase
  end

  assign hit = sample & det_w;

  // Control FSM with registered handshake/detector-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      hit_cnt  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      det_rst  <= 1'b1;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (hit) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            hit_cnt  <= '0;
            bit_idx  <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            det_rst  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == CNT_W'(WIDTH - 1)) begin
            state <= TAIL;
          end
        end
        TAIL: begin
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          det_rst <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_CTRL_HIT_POS_EN
  logic [CNT_W-1:0] sample_pos;

  // In SHIFT the sample refers to bit number bit_idx (1-based); in TAIL it
  // refers to the last bit, WIDTH.
  assign sample_pos = (state == TAIL) ? CNT_W'(WIDTH) : bit_idx;

  // Capture the position of the first hit only; zero marks "no hit yet".
  always_ff @(posedge clk) begin
    if (rst) begin
      first_hit_pos <= '0;
    end else if (state == IDLE && in_valid) begin
      first_hit_pos <= '0;
    end else if (hit && first_hit_pos == '0) begin
      first_hit_pos <= sample_pos;
    end
  end
`else
  // No hit-position tracking in this build.
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl (WIDTH=8) paired with an overlapping "111" Moore
// detector model. A cycle-level reference derived from word contents and the
// accept/done timeline is compared against the DUT on every cycle, alongside
// directed scenarios with hand-computed literal results.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          det_rst;
  logic          det_ser;
  logic          det_w;
  logic          busy;
  logic          done;
  logic [CW-1:0] hit_cnt;
`ifdef SEQ_CTRL_HIT_POS_EN
  logic [CW-1:0] first_hit_pos;
`endif

  int tests = 0;
  int fails = 0;

  logic       force_w = 1'b0;
  logic [2:0] hist;
  logic       chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .det_rst(det_rst), .det_ser(det_ser), .det_w(det_w),
    .busy(busy), .done(done), .hit_cnt(hit_cnt)
`ifdef SEQ_CTRL_HIT_POS_EN
    , .first_hit_pos(first_hit_pos)
`endif
  );

  // External detector: Moore flag when the last three serial bits were 1.
  always @(posedge clk) begin
    if (det_rst) hist <= 3'b000;
    else         hist <= {hist[1:0], det_ser};
  end
  assign det_w = force_w | (&hist);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from the word itself: bit i (1-based, MSB first)
  // completes a hit when it and the two bits before it are all 1.
  function automatic int ref_hits(input logic [W-1:0] w);
    int n = 0;
    for (int i = 3; i <= W; i++)
      if (w[W-i] && w[W-i+1] && w[W-i+2]) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [W-1:0] w);
    for (int i = 3; i <= W; i++)
      if (w[W-i] && w[W-i+1] && w[W-i+2]) return i;
    return 0;
  endfunction

  // Timeline reference: m_pos = cycles since accept (1..W+2), -1 when idle.
  int         m_pos = -1;
  logic [W-1:0] m_word = '0;
  int         m_cnt = 0;
  int         m_first = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1; m_cnt = 0; m_first = 0;
    end else if (m_pos == -1) begin
      if (in_valid) begin
        m_pos = 1; m_word = in_data;
        m_cnt = ref_hits(in_data); m_first = ref_first(in_data);
      end
    end else if (m_pos == W + 2) begin
      m_pos = -1;
    end else begin
      m_pos = m_pos + 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the timeline reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(m_pos == -1));
      chk("busy", int'(busy), int'(m_pos >= 1 && m_pos <= W + 1));
      chk("done", int'(done), int'(m_pos == W + 2));
      chk("det_rst", int'(det_rst), int'(m_pos == -1 || m_pos == W + 2));
      chk("det_ser", int'(det_ser), (m_pos >= 1 && m_pos <= W) ? int'(m_word[W-m_pos]) : 0);
      if (m_pos == -1 || m_pos == W + 2) begin
        chk("hit_cnt", int'(hit_cnt), m_cnt);
`ifdef SEQ_CTRL_HIT_POS_EN
        chk("first_hit_pos", int'(first_hit_pos), m_first);
`endif
      end
    end
  end

  // Raise valid, wait for ready, let the accept edge pass; returns in cycle 1.
  task automatic send_accept(input logic [W-1:0] w);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for done; c is the cycle number (relative to accept) it appeared in.
  task automatic wait_done(input int start, output int c);
    c = start - 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); c++;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
    c = -1;
  endtask

  task automatic run_word(input logic [W-1:0] w, input int exp_cnt, input int exp_pos);
    int c;
    send_accept(w);
    wait_done(1, c);
    chk("done_latency", c, W + 2);
    chk("word_hit_cnt", int'(hit_cnt), exp_cnt);
`ifdef SEQ_CTRL_HIT_POS_EN
    chk("word_first_pos", int'(first_hit_pos), exp_pos);
`else
    if (exp_pos < 0) chk("word_first_pos", exp_pos, 0);
`endif
  endtask

  initial begin
    int c;
    int ndone;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_det_rst", int'(det_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_det_ser", int'(det_ser), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    chk_en = 1'b1;

    // Directed words with hand-computed results.
    run_word(8'b00111110, 3, 5);
    run_word(8'hFF, 6, 3);
    run_word(8'h00, 0, 0);

    // Stale detector output in the first SHIFT cycle must be ignored.
    send_accept(8'h00);
    force_w = 1'b1;
    @(posedge clk); #1 force_w = 1'b0;
    wait_done(2, c);
    chk("force_latency", c, W + 2);
    chk("force_hit_cnt", int'(hit_cnt), 0);

    // Valid held across two words.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    chk("hold_ready0", int'(in_ready), 1);
    @(posedge clk);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      chk("hold_rdy_low", int'(in_ready), 0);
    end
    chk("hold_done1", int'(done), 1);
    chk("hold_cnt1", int'(hit_cnt), 6);
    in_data = 8'b10110110;
    @(negedge clk);
    chk("hold_rdy11", int'(in_ready), 1);
    chk("hold_cnt11", int'(hit_cnt), 6);
    chk("hold_detrst11", int'(det_rst), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(1, c);
    chk("hold_latency2", c, W + 2);
    chk("hold_cnt2", int'(hit_cnt), 0);

    // Reset during SHIFT cycle 4 drops the word without a done pulse.
    send_accept(8'hFF);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_detrst", int'(det_rst), 1);
    chk("mid_rst_cnt", int'(hit_cnt), 0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", ndone, 0);
    run_word(8'b00111110, 3, 5);

    // Randomized traffic with occasional resets, checked every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = ($urandom_range(0, 1) == 1) ? (8'($urandom) | 8'($urandom)) : 8'($urandom);
      rst      = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    repeat (15) @(posedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Controller that sequences an external serial sequence-detector datapath (clk/rst/serIn in, Moore detect flag out).
- Accepts a parallel word over a valid/ready handshake and resets the detector before each word.
- Streams the word MSB-first into the detector, one bit per clock, and counts detector hits.
- Reports the hit count with a one-cycle done pulse; sits between a parallel producer and the serial detector.

Parameters:
- WIDTH, 8, bits per word streamed to the detector (>=2).
- CNT_W, $clog2(WIDTH+1), width of hit counter and position fields.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept a word (IDLE only).
- in_data  in  WIDTH  word to stream, MSB sent first.
- det_rst  out  1  drives detector rst.
- det_ser  out  1  drives detector serIn.
- det_w  in  1  detector Moore output.
- busy  out  1  high in SHIFT and TAIL.
- done  out  1  one-cycle pulse when hit_cnt is final.
- hit_cnt  out  CNT_W  hits in the last word; held until the next accept.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, shreg=0, bit_idx=0, hit_cnt=0.
  - done=0, busy=0, det_ser=0, det_rst=1, in_ready=1.
- FSM states: IDLE, SHIFT, TAIL, DONE.
- IDLE:
  - Outputs: in_ready=1, det_rst=1 (detector held cleared), det_ser=0.
  - On in_valid: latch in_data into shreg, clear hit_cnt and bit_idx, go to SHIFT. The accept cycle is cycle 0.
- SHIFT (cycles 1..WIDTH):
  - Outputs: det_rst=0, det_ser=shreg[WIDTH-1].
  - Each clock: shift shreg left by 1 and increment bit_idx.
  - Sample det_w when bit_idx!=0; det_w reflects the previous bit (Moore, one-cycle latency), so det_w at bit_idx=0 is ignored.
  - On det_w=1, hit_cnt++.
  - At bit_idx==WIDTH-1, go to TAIL.
- TAIL (cycle WIDTH+1):
  - Outputs: det_ser=0, det_rst=0.
  - Sample det_w for the last bit; on 1, hit_cnt++. Go to DONE.
- DONE (cycle WIDTH+2):
  - Outputs: done=1, det_rst=1, in_ready=0. Go to IDLE.
  - Earliest next accept is cycle WIDTH+3.
- Counter width: at most WIDTH samples are taken, so hit_cnt<=WIDTH fits CNT_W and cannot overflow; no saturation logic.
- Handshake:
  - in_data is sampled only when in_valid && in_ready.
  - in_valid while busy is ignored and not queued; the producer holds it.
- Reset mid-operation: rst in any state returns to IDLE with reset values next cycle; the partial word is dropped and no done pulse is issued.
- hit_cnt is stable from DONE until the next accept.

Optional Feature:
- Macro SEQ_CTRL_HIT_POS_EN.
- Defined:
  - Adds output first_hit_pos [CNT_W]: 1-based index of the bit that completed the first hit of the word; 0 if no hit.
  - Cleared on accept, written once per word, valid with done, held like hit_cnt.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package seq_ctrl_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, TAIL, DONE};
  - a localparam function for CNT_W.
- No sub-module; the detector stays external and is wired by the parent.
- The bench pairs the controller with a detector model flagging overlapping "111" (Moore).

Test Plan (WIDTH=8):
- Word 8'b00111110 -> bits 0,0,1,1,1,1,1,0 -> hit_cnt=3 at done in cycle 10; first_hit_pos=5 if enabled.
- Word 8'hFF -> hit_cnt=6, first_hit_pos=3; word 8'h00 -> hit_cnt=0, first_hit_pos=0.
- Force det_w=1 during the first SHIFT cycle (bit_idx=0) with 8'h00 -> hit_cnt=0, confirming the stale sample is ignored.
- Hold in_valid through two words 8'hFF then 8'b10110110:
  - in_ready low cycles 1..10;
  - second accept in cycle 11;
  - hit_cnt=6 held from cycle 10 until the second accept, then the second result is 0;
  - det_rst=1 in DONE/IDLE between words.
- Assert rst at SHIFT cycle 4 of 8'hFF -> next cycle IDLE, hit_cnt=0, det_rst=1, no done pulse; a fresh word afterwards counts correctly.
